// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder
//   Memory-side responder for the microcoded CPU port. The CPU reads the
//   2**aW-word array combinationally and writes it on the rising clock edge.
//   A valid/ready bulk loader can fill the array while the CPU is held off.
//   Optional feature macro: PROTECT_EN. When it is defined, CPU writes below
//   PROT_TOP are dropped and the sticky wr_fault flag is raised.
//   The array contents are never cleared by reset, so a preload survives a
//   CPU reset.

module cpu_mem_responder #(
    parameter int Wwid     = 6,
    parameter int aW       = 8,
    parameter int PROT_TOP = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [aW-1:0]   memAddr,
    output logic [Wwid-1:0] readData,
    input  logic [Wwid-1:0] writeData,
    input  logic            writeEn,
    input  logic            ld_start,
    input  logic [aW-1:0]   ld_base,
    input  logic [aW-1:0]   ld_len,
    input  logic            ld_valid,
    input  logic [Wwid-1:0] ld_data,
    output logic            ld_ready,
    output logic            cpu_hold,
    output logic            ld_done,
    output logic [7:0]      wr_count,
    output logic            wr_fault
);

    localparam int DEPTH = 2 ** aW;
    localparam logic [aW-1:0] PROT_LIM = aW'(PROT_TOP);
    localparam logic [aW-1:0] REM_LAST = aW'(1);

`ifdef PROTECT_EN
    localparam bit PROTECT = 1'b1;
`else
    localparam bit PROTECT = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_d;
    logic [aW-1:0]   ptr, ptr_d;
    logic [aW-1:0]   rem, rem_d;
    logic            ld_hs;
    logic            cpu_we;
    logic            cpu_reject;
    logic            prot_hit;

    logic [Wwid-1:0] mem [DEPTH];

    // Zero-latency read in every state; a same-cycle write shows up only after the edge.
    assign readData = mem[memAddr];

    // Address falls inside the protected low region (only meaningful with PROTECT_EN).
    assign prot_hit = PROTECT && (memAddr < PROT_LIM);

    // Next-state, loader pointer and write-strobe decode.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d    = state;
        ptr_d      = ptr;
        rem_d      = rem;
        ld_hs      = 1'b0;
        cpu_we     = 1'b0;
        cpu_reject = 1'b0;

        case (state)
            IDLE: begin
                if (writeEn) begin
                    if (prot_hit) cpu_reject = 1'b1;
                    else          cpu_we     = 1'b1;
                end
                if (ld_start) begin
                    if (ld_len != '0) begin
                        state_d = LOAD;
                        ptr_d   = ld_base;
                        rem_d   = ld_len;
                    end else begin
                        state_d = DONE;
                    end
                end
            end

            LOAD: begin
                // CPU writes and ld_start are deliberately ignored here.
                ld_hs = ld_valid && ld_ready;
                if (ld_hs) begin
                    ptr_d = ptr + 1'b1;  // wraps modulo 2**aW
                    rem_d = rem - 1'b1;
                    if (rem == REM_LAST) state_d = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, loader bookkeeping and registered handshake/status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ptr      <= '0;
            rem      <= '0;
            ld_ready <= 1'b0;
            cpu_hold <= 1'b0;
            ld_done  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state    <= state_d;
            ptr      <= ptr_d;
            rem      <= rem_d;
            ld_ready <= (state_d == LOAD);
            cpu_hold <= (state_d != IDLE);
            ld_done  <= (state_d == DONE);
        end
    end

    // Saturating count of CPU writes that actually reached the array.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_count <= 8'd0;
        end else if (cpu_we && (wr_count != 8'hFF)) begin
            wr_count <= wr_count + 8'd1;
        end
    end

`ifdef PROTECT_EN
    // Sticky flag: some CPU write hit the protected region since reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_fault <= 1'b0;
        end else if (cpu_reject) begin
            wr_fault <= 1'b1;
        end
    end
`else
    assign wr_fault = 1'b0;
`endif

    // Single array write port; loader and CPU are mutually exclusive by state.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset so contents persist across rst and map to plain RAM.
        if (ld_hs) begin
            mem[ptr] <= ld_data;
        end else if (cpu_we) begin
            mem[memAddr] <= writeData;
        end
    end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb_cpu_mem_responder
//   Directed test of cpu_mem_responder: loader preload, wrapping load with
//   a valid gap, CPU writes ignored while held, write-count saturation,
//   write-with-start overlap, reset mid-load, zero-length load, protection.
//   Define PROTECT_EN for both this file and the RTL to exercise protection.

module tb_cpu_mem_responder;

    localparam int W = 6;
    localparam int A = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [A-1:0] memAddr;
    logic [W-1:0] readData;
    logic [W-1:0] writeData;
    logic         writeEn;
    logic         ld_start;
    logic [A-1:0] ld_base;
    logic [A-1:0] ld_len;
    logic         ld_valid;
    logic [W-1:0] ld_data;
    logic         ld_ready;
    logic         cpu_hold;
    logic         ld_done;
    logic [7:0]   wr_count;
    logic         wr_fault;

    int n_checks = 0;
    int n_errors = 0;
    int done_pulses;
    logic [W-1:0] words [8];

    cpu_mem_responder #(.Wwid(W), .aW(A), .PROT_TOP(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .memAddr   (memAddr),
        .readData  (readData),
        .writeData (writeData),
        .writeEn   (writeEn),
        .ld_start  (ld_start),
        .ld_base   (ld_base),
        .ld_len    (ld_len),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .cpu_hold  (cpu_hold),
        .ld_done   (ld_done),
        .wr_count  (wr_count),
        .wr_fault  (wr_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 2 time units after the edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic rd_check(input string tag, input logic [A-1:0] a, input logic [W-1:0] exp);
        memAddr = a;
        #1;
        check(tag, 32'(readData), 32'(exp));
    endtask

    task automatic cpu_write(input logic [A-1:0] a, input logic [W-1:0] d);
        memAddr   = a;
        writeData = d;
        writeEn   = 1'b1;
        step();
        writeEn   = 1'b0;
    endtask

    // Back-to-back load of words[0..len-1]; ends after the DONE cycle.
    task automatic do_load(input string tag, input logic [A-1:0] base, input int len);
        ld_base  = base;
        ld_len   = A'(len);
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        for (int i = 0; i < len; i++) begin
            ld_valid = 1'b1;
            ld_data  = words[i];
            step();
        end
        ld_valid = 1'b0;
        check({tag, "_done"}, 32'(ld_done), 32'd1);
        step();
        check({tag, "_hold_off"}, 32'(cpu_hold), 32'd0);
    endtask

    initial begin
        rst       = 1'b0;
        memAddr   = '0;
        writeData = '0;
        writeEn   = 1'b0;
        ld_start  = 1'b0;
        ld_base   = '0;
        ld_len    = '0;
        ld_valid  = 1'b0;
        ld_data   = '0;
        #1;
        check("rst_ready", 32'(ld_ready), 32'd0);
        check("rst_hold",  32'(cpu_hold), 32'd0);
        check("rst_done",  32'(ld_done),  32'd0);
        check("rst_count", 32'(wr_count), 32'd0);
        check("rst_fault", 32'(wr_fault), 32'd0);
        step();
        rst = 1'b1;
        step();

        // 1. preload one word and read it back combinationally
        words[0] = 6'h2A;
        do_load("t1", 8'h10, 1);
        rd_check("t1_read", 8'h10, 6'h2A);

        // read-during-write returns the old word until the edge
        memAddr   = 8'h10;
        writeData = 6'h15;
        writeEn   = 1'b1;
        #1;
        check("rdw_old", 32'(readData), 32'h2A);
        step();
        writeEn = 1'b0;
        rd_check("rdw_new", 8'h10, 6'h15);
        check("rdw_count", 32'(wr_count), 32'd1);

        // 2. wrapping load with a one-cycle valid gap after the first word
        done_pulses = 0;
        ld_base  = 8'hFE;
        ld_len   = 8'd3;
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        check("t2_hold_first", 32'(cpu_hold), 32'd1);
        check("t2_ready_first", 32'(ld_ready), 32'd1);
        ld_valid = 1'b1; ld_data = 6'd1; step();
        done_pulses += int'(ld_done);
        ld_valid = 1'b0; step();
        done_pulses += int'(ld_done);
        check("t2_ready_gap", 32'(ld_ready), 32'd1);
        check("t2_hold_gap",  32'(cpu_hold), 32'd1);
        ld_valid = 1'b1; ld_data = 6'd2; step();
        done_pulses += int'(ld_done);
        ld_data = 6'd3; step();
        ld_valid = 1'b0;
        done_pulses += int'(ld_done);
        check("t2_done_ready", 32'(ld_ready), 32'd0);
        check("t2_done_hold",  32'(cpu_hold), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            done_pulses += int'(ld_done);
        end
        check("t2_done_pulses", 32'(done_pulses), 32'd1);
        check("t2_hold_idle",   32'(cpu_hold), 32'd0);
        rd_check("t2_fe", 8'hFE, 6'd1);
        rd_check("t2_ff", 8'hFF, 6'd2);
        rd_check("t2_00", 8'h00, 6'd3);

        // 3. CPU write during LOAD is ignored
        cpu_write(8'h20, 6'h0C);
        check("t3_pre_count", 32'(wr_count), 32'd2);
        ld_base  = 8'h30;
        ld_len   = 8'd1;
        ld_start = 1'b1;
        step();
        ld_start  = 1'b0;
        memAddr   = 8'h20;
        writeData = 6'h33;
        writeEn   = 1'b1;
        step();
        step();
        writeEn  = 1'b0;
        ld_valid = 1'b1;
        ld_data  = 6'h21;
        step();
        ld_valid = 1'b0;
        step();
        rd_check("t3_mem20", 8'h20, 6'h0C);
        check("t3_count", 32'(wr_count), 32'd2);

        // 4. write-count saturation
        for (int i = 0; i < 256; i++) cpu_write(8'h80, 6'(i));
        check("t4_sat", 32'(wr_count), 32'd255);
        rd_check("t4_last", 8'h80, 6'h3F);

        // same-cycle CPU write and ld_start
        memAddr   = 8'h31;
        writeData = 6'h11;
        writeEn   = 1'b1;
        ld_base   = 8'h40;
        ld_len    = 8'd1;
        ld_start  = 1'b1;
        step();
        writeEn  = 1'b0;
        ld_start = 1'b0;
        check("t4_overlap_load", 32'(ld_ready), 32'd1);
        ld_valid = 1'b1;
        ld_data  = 6'h22;
        step();
        ld_valid = 1'b0;
        check("t4_overlap_done", 32'(ld_done), 32'd1);
        step();
        rd_check("t4_cpu_word", 8'h31, 6'h11);
        rd_check("t4_ld_word",  8'h40, 6'h22);

        // zero-length load goes straight to DONE
        ld_base  = 8'h50;
        ld_len   = 8'd0;
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        check("zl_done",  32'(ld_done),  32'd1);
        check("zl_ready", 32'(ld_ready), 32'd0);
        check("zl_hold",  32'(cpu_hold), 32'd1);
        step();
        check("zl_idle", 32'(cpu_hold), 32'd0);

        // 5. reset in the middle of a 5-word load
        ld_base  = 8'h50;
        ld_len   = 8'd5;
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        ld_valid = 1'b1; ld_data = 6'h05; step();
        ld_data = 6'h06; step();
        ld_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("t5_hold",  32'(cpu_hold), 32'd0);
        check("t5_ready", 32'(ld_ready), 32'd0);
        check("t5_count", 32'(wr_count), 32'd0);
        step();
        rst = 1'b1;
        step();
        check("t5_idle_ready", 32'(ld_ready), 32'd0);
        rd_check("t5_w0", 8'h50, 6'h05);
        rd_check("t5_w1", 8'h51, 6'h06);
        rd_check("t5_keep", 8'h10, 6'h15);

        // 6. protection of the low region
        words[0] = 6'h07;
        do_load("t6", 8'h02, 1);
        cpu_write(8'h02, 6'h3F);
`ifdef PROTECT_EN
        rd_check("t6_prot_mem", 8'h02, 6'h07);
        check("t6_fault", 32'(wr_fault), 32'd1);
        check("t6_count", 32'(wr_count), 32'd0);
`else
        rd_check("t6_open_mem", 8'h02, 6'h3F);
        check("t6_fault", 32'(wr_fault), 32'd0);
        check("t6_count", 32'(wr_count), 32'd1);
`endif
        cpu_write(8'h04, 6'h3F);
        rd_check("t6_addr4", 8'h04, 6'h3F);
`ifdef PROTECT_EN
        check("t6_count4", 32'(wr_count), 32'd1);
        check("t6_fault_sticky", 32'(wr_fault), 32'd1);
`else
        check("t6_count4", 32'(wr_count), 32'd2);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
